// File: rtl/branch_predictor.sv
// Dynamic branch predictor for IF: tagged BTB, 2-bit counter PHT and a
// speculative global history register repaired from EX on mispredictions.
module branch_predictor #(
    parameter int XLEN     = 32,
    parameter int IDX_BITS = 5,
    parameter int GHR_BITS = 5,
    parameter int MODE     = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [XLEN-1:0]     pred_pc,
    input  logic                stall,
    output logic                pred_taken,
    output logic [XLEN-1:0]     pred_next_pc,
    output logic [GHR_BITS-1:0] pred_ghr,
    input  logic                upd_valid,
    input  logic [XLEN-1:0]     upd_pc,
    input  logic                upd_is_branch,
    input  logic                upd_is_jump,
    input  logic                upd_taken,
    input  logic [XLEN-1:0]     upd_target,
    input  logic [GHR_BITS-1:0] upd_ghr,
    input  logic                upd_mispredict
);

    localparam int   ENTRIES   = 1 << IDX_BITS;
    localparam int   TAG_BITS  = XLEN - IDX_BITS - 2;
    localparam logic IS_STATIC = (MODE == 0);
    localparam logic IS_GSHARE = (MODE == 2);

    logic                btb_valid_r  [ENTRIES];
    logic [TAG_BITS-1:0] btb_tag_r    [ENTRIES];
    logic [XLEN-1:0]     btb_target_r [ENTRIES];
    logic                btb_jump_r   [ENTRIES];
    logic [1:0]          pht_r        [ENTRIES];
    logic [GHR_BITS-1:0] ghr_r;

    logic [IDX_BITS-1:0] pred_idx_s;
    logic [TAG_BITS-1:0] pred_tag_s;
    logic [IDX_BITS-1:0] pred_pidx_s;
    logic                hit_s;
    logic                taken_s;
    logic [IDX_BITS-1:0] upd_idx_s;
    logic [TAG_BITS-1:0] upd_tag_s;
    logic [IDX_BITS-1:0] upd_pidx_s;
    logic                unused_s;

    function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
        logic [1:0] r;
        if (taken) begin
            r = (ctr == 2'b11) ? 2'b11 : ctr + 2'b01;
        end else begin
            r = (ctr == 2'b00) ? 2'b00 : ctr - 2'b01;
        end
        return r;
    endfunction

    // Written so GHR_BITS == 1 needs no special case.
    function automatic logic [GHR_BITS-1:0] shift_in(input logic [GHR_BITS-1:0] h, input logic b);
        logic [GHR_BITS:0] w;
        w = {h, b};
        return w[GHR_BITS-1:0];
    endfunction

    function automatic logic [IDX_BITS-1:0] pht_index(input logic [IDX_BITS-1:0] idx,
                                                      input logic [GHR_BITS-1:0] ghr);
        logic [IDX_BITS-1:0] r;
        if (IS_GSHARE) begin
            r = idx ^ IDX_BITS'(ghr);
        end else begin
            r = idx;
        end
        return r;
    endfunction

    assign unused_s = ^upd_pc[1:0];

    // Combinational lookup of the PC in IF against current state.
    always_comb begin
        pred_idx_s  = pred_pc[IDX_BITS+1:2];
        pred_tag_s  = pred_pc[XLEN-1:IDX_BITS+2];
        pred_pidx_s = pht_index(pred_idx_s, ghr_r);
        hit_s       = btb_valid_r[pred_idx_s] && (btb_tag_r[pred_idx_s] == pred_tag_s);
        if (IS_STATIC) begin
            taken_s = 1'b0;
        end else begin
            taken_s = hit_s && (btb_jump_r[pred_idx_s] || pht_r[pred_pidx_s][1]);
        end
        pred_taken   = taken_s;
        pred_next_pc = taken_s ? btb_target_r[pred_idx_s] : pred_pc + XLEN'(3'd4);
        pred_ghr     = ghr_r;
    end

    // Training indices come from the resolved PC and the history it was fetched with.
    always_comb begin
        upd_idx_s  = upd_pc[IDX_BITS+1:2];
        upd_tag_s  = upd_pc[XLEN-1:IDX_BITS+2];
        upd_pidx_s = pht_index(upd_idx_s, upd_ghr);
    end

    // Valid bits and counters: cleared on reset, trained from EX.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                btb_valid_r[i] <= 1'b0;
                pht_r[i]       <= 2'b01;
            end
        end else begin
            if (upd_valid && upd_is_branch) begin
                pht_r[upd_pidx_s] <= ctr_next(pht_r[upd_pidx_s], upd_taken);
            end
            if (upd_valid && upd_taken) begin
                btb_valid_r[upd_idx_s] <= 1'b1;
            end
        end
    end

    // BTB payload; only meaningful behind a valid bit, so it carries no reset.
    always_ff @(posedge clk) begin
        if (!reset && upd_valid && upd_taken) begin
            btb_tag_r[upd_idx_s]    <= upd_tag_s;
            btb_target_r[upd_idx_s] <= upd_target;
            btb_jump_r[upd_idx_s]   <= upd_is_jump;
        end
    end

    // Speculative history with repair taking priority over the fetch-side shift.
    always_ff @(posedge clk) begin
        if (reset || !IS_GSHARE) begin
            ghr_r <= {GHR_BITS{1'b0}};
        end else if (upd_valid && upd_mispredict) begin
            ghr_r <= upd_is_branch ? shift_in(upd_ghr, upd_taken) : upd_ghr;
        end else if (!stall && hit_s && !btb_jump_r[pred_idx_s]) begin
            ghr_r <= shift_in(ghr_r, taken_s);
        end else begin
            ghr_r <= ghr_r;
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench driving static, bimodal and gshare instances with shared
// stimulus; expectations are queued at drive time and checked the same cycle.
module tb_branch_predictor;

    localparam int NONE = 0;
    localparam int BR   = 1;
    localparam int JMP  = 2;

    logic        clk;
    logic        reset;
    logic [31:0] pred_pc;
    logic        stall;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_is_branch;
    logic        upd_is_jump;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic [4:0]  upd_ghr;
    logic        upd_mispredict;

    logic        sta_taken, bim_taken, gsh_taken;
    logic [31:0] sta_npc, bim_npc, gsh_npc;
    logic [4:0]  sta_ghr, bim_ghr, gsh_ghr;

    typedef struct {
        logic        rst;
        logic [31:0] pc;
        logic        stall;
        int          kind;
        logic [31:0] upc;
        logic        utk;
        logic [31:0] utgt;
        logic [4:0]  ughr;
        logic        umis;
        logic [2:0]  chk;   // bit0 static, bit1 bimodal, bit2 gshare
        logic [2:0]  etk;
        logic [31:0] etgt;
        logic [4:0]  eghr;  // gshare history; other modes expect 0
    } step_t;

    typedef struct {
        int          dut;
        logic [37:0] val;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    branch_predictor #(.XLEN(32), .IDX_BITS(5), .GHR_BITS(5), .MODE(0)) u_sta (
        .clk(clk), .reset(reset), .pred_pc(pred_pc), .stall(stall),
        .pred_taken(sta_taken), .pred_next_pc(sta_npc), .pred_ghr(sta_ghr),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_is_branch(upd_is_branch),
        .upd_is_jump(upd_is_jump), .upd_taken(upd_taken), .upd_target(upd_target),
        .upd_ghr(upd_ghr), .upd_mispredict(upd_mispredict)
    );

    branch_predictor #(.XLEN(32), .IDX_BITS(5), .GHR_BITS(5), .MODE(1)) u_bim (
        .clk(clk), .reset(reset), .pred_pc(pred_pc), .stall(stall),
        .pred_taken(bim_taken), .pred_next_pc(bim_npc), .pred_ghr(bim_ghr),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_is_branch(upd_is_branch),
        .upd_is_jump(upd_is_jump), .upd_taken(upd_taken), .upd_target(upd_target),
        .upd_ghr(upd_ghr), .upd_mispredict(upd_mispredict)
    );

    branch_predictor #(.XLEN(32), .IDX_BITS(5), .GHR_BITS(5), .MODE(2)) u_gsh (
        .clk(clk), .reset(reset), .pred_pc(pred_pc), .stall(stall),
        .pred_taken(gsh_taken), .pred_next_pc(gsh_npc), .pred_ghr(gsh_ghr),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_is_branch(upd_is_branch),
        .upd_is_jump(upd_is_jump), .upd_taken(upd_taken), .upd_target(upd_target),
        .upd_ghr(upd_ghr), .upd_mispredict(upd_mispredict)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic step_t mk(input logic rst, input logic [31:0] pc, input logic stl,
                                 input int kind, input logic [31:0] upc, input logic utk,
                                 input logic [31:0] utgt, input logic [4:0] ughr, input logic umis,
                                 input logic [2:0] chk, input logic [2:0] etk,
                                 input logic [31:0] etgt, input logic [4:0] eghr);
        step_t s;
        s.rst = rst; s.pc = pc; s.stall = stl; s.kind = kind; s.upc = upc; s.utk = utk;
        s.utgt = utgt; s.ughr = ughr; s.umis = umis; s.chk = chk; s.etk = etk;
        s.etgt = etgt; s.eghr = eghr;
        return s;
    endfunction

    function automatic logic [37:0] observe(input int d);
        logic [37:0] r;
        case (d)
            0:       r = {sta_taken, sta_npc, sta_ghr};
            1:       r = {bim_taken, bim_npc, bim_ghr};
            default: r = {gsh_taken, gsh_npc, gsh_ghr};
        endcase
        return r;
    endfunction

    // Drives one cycle of inputs and queues the expected lookup results.
    task automatic drive_step(input step_t s);
        exp_t e;
        reset          = s.rst;
        pred_pc        = s.pc;
        stall          = s.stall;
        upd_valid      = (s.kind != NONE);
        upd_is_branch  = (s.kind == BR);
        upd_is_jump    = (s.kind == JMP);
        upd_pc         = s.upc;
        upd_taken      = s.utk;
        upd_target     = s.utgt;
        upd_ghr        = s.ughr;
        upd_mispredict = s.umis;
        for (int d = 0; d < 3; d++) begin
            if (s.chk[d]) begin
                e.dut = d;
                e.val = {s.etk[d], (s.etk[d] ? s.etgt : s.pc + 32'd4), ((d == 2) ? s.eghr : 5'd0)};
                sb.push_back(e);
            end
        end
    endtask

    task automatic test_reset();
        step_t s[$];
        exp_t e;
        logic [37:0] obs;
        s.push_back(mk(1'b1, 32'h100, 1'b0, NONE, 32'h0, 1'b0, 32'h0, 5'd0, 1'b0, 3'b000, 3'b000, 32'h0, 5'd0));
        s.push_back(mk(1'b1, 32'h100, 1'b0, NONE, 32'h0, 1'b0, 32'h0, 5'd0, 1'b0, 3'b000, 3'b000, 32'h0, 5'd0));
        s.push_back(mk(1'b0, 32'h100, 1'b0, NONE, 32'h0, 1'b0, 32'h0, 5'd0, 1'b0, 3'b111, 3'b000, 32'h0, 5'd0));
        s.push_back(mk(1'b0, 32'h40,  1'b0, NONE, 32'h0, 1'b0, 32'h0, 5'd0, 1'b0, 3'b111, 3'b000, 32'h0, 5'd0));
        for (int i = 0; i < s.size(); i++) begin
            drive_step(s[i]);
            #1;
            while (sb.size() > 0) begin
                e = sb.pop_front();
                obs = observe(e.dut);
                vectors++;
                if (obs !== e.val) begin
                    miscompares++;
                    $display("FAIL reset step %0d dut %0d: got taken=%b npc=%h ghr=%b, expected taken=%b npc=%h ghr=%b",
                             i, e.dut, obs[37], obs[36:5], obs[4:0], e.val[37], e.val[36:5], e.val[4:0]);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_bimodal();
        step_t s[$];
        exp_t e;
        logic [37:0] obs;
        s.push_back(mk(1'b1, 32'h100, 1'b0, NONE, 32'h0,  1'b0, 32'h0,   5'd0, 1'b0, 3'b000, 3'b000, 32'h0,   5'd0));
        s.push_back(mk(1'b0, 32'h100, 1'b0, BR,   32'h40, 1'b1, 32'h80,  5'd0, 1'b0, 3'b111, 3'b000, 32'h0,   5'd0));
        s.push_back(mk(1'b0, 32'h100, 1'b0, BR,   32'h40, 1'b1, 32'h80,  5'd0, 1'b0, 3'b111, 3'b000, 32'h0,   5'd0));
        s.push_back(mk(1'b0, 32'h40,  1'b1, NONE, 32'h0,  1'b0, 32'h0,   5'd0, 1'b0, 3'b111, 3'b110, 32'h80,  5'd0));
        s.push_back(mk(1'b0, 32'h100, 1'b0, BR,   32'h40, 1'b0, 32'h80,  5'd0, 1'b0, 3'b111, 3'b000, 32'h0,   5'd0));
        s.push_back(mk(1'b0, 32'h100, 1'b0, BR,   32'h40, 1'b0, 32'h80,  5'd0, 1'b0, 3'b111, 3'b000, 32'h0,   5'd0));
        s.push_back(mk(1'b0, 32'h40,  1'b1, NONE, 32'h0,  1'b0, 32'h0,   5'd0, 1'b0, 3'b111, 3'b000, 32'h0,   5'd0));
        // Gshare counter 16 raised through another PC; bimodal trains counter 17.
        s.push_back(mk(1'b0, 32'h100, 1'b0, BR,   32'h44, 1'b1, 32'h300, 5'd1, 1'b0, 3'b111, 3'b000, 32'h0,   5'd0));
        s.push_back(mk(1'b0, 32'h100, 1'b0, BR,   32'h44, 1'b1, 32'h300, 5'd1, 1'b0, 3'b111, 3'b000, 32'h0,   5'd0));
        s.push_back(mk(1'b0, 32'h40,  1'b1, NONE, 32'h0,  1'b0, 32'h0,   5'd0, 1'b0, 3'b111, 3'b100, 32'h80,  5'd0));
        s.push_back(mk(1'b0, 32'h44,  1'b1, NONE, 32'h0,  1'b0, 32'h0,   5'd0, 1'b0, 3'b111, 3'b010, 32'h300, 5'd0));
        for (int i = 0; i < s.size(); i++) begin
            drive_step(s[i]);
            #1;
            while (sb.size() > 0) begin
                e = sb.pop_front();
                obs = observe(e.dut);
                vectors++;
                if (obs !== e.val) begin
                    miscompares++;
                    $display("FAIL bimodal step %0d dut %0d: got taken=%b npc=%h ghr=%b, expected taken=%b npc=%h ghr=%b",
                             i, e.dut, obs[37], obs[36:5], obs[4:0], e.val[37], e.val[36:5], e.val[4:0]);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_jump_alias();
        step_t s[$];
        exp_t e;
        logic [37:0] obs;
        s.push_back(mk(1'b1, 32'h100, 1'b0, NONE, 32'h0,  1'b0, 32'h0,   5'd0, 1'b0, 3'b000, 3'b000, 32'h0,   5'd0));
        s.push_back(mk(1'b0, 32'h20,  1'b0, JMP,  32'h20, 1'b1, 32'h200, 5'd0, 1'b0, 3'b111, 3'b000, 32'h0,   5'd0));
        s.push_back(mk(1'b0, 32'h20,  1'b0, NONE, 32'h0,  1'b0, 32'h0,   5'd0, 1'b0, 3'b111, 3'b110, 32'h200, 5'd0));
        s.push_back(mk(1'b0, 32'hA0,  1'b0, NONE, 32'h0,  1'b0, 32'h0,   5'd0, 1'b0, 3'b111, 3'b000, 32'h0,   5'd0));
        for (int i = 0; i < s.size(); i++) begin
            drive_step(s[i]);
            #1;
            while (sb.size() > 0) begin
                e = sb.pop_front();
                obs = observe(e.dut);
                vectors++;
                if (obs !== e.val) begin
                    miscompares++;
                    $display("FAIL jump_alias step %0d dut %0d: got taken=%b npc=%h ghr=%b, expected taken=%b npc=%h ghr=%b",
                             i, e.dut, obs[37], obs[36:5], obs[4:0], e.val[37], e.val[36:5], e.val[4:0]);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_ghr_shift();
        step_t s[$];
        exp_t e;
        logic [37:0] obs;
        s.push_back(mk(1'b1, 32'h100, 1'b0, NONE, 32'h0,  1'b0, 32'h0,  5'd0, 1'b0, 3'b000, 3'b000, 32'h0,  5'd0));
        s.push_back(mk(1'b0, 32'h100, 1'b0, BR,   32'h40, 1'b1, 32'h80, 5'd0, 1'b0, 3'b111, 3'b000, 32'h0,  5'd0));
        s.push_back(mk(1'b0, 32'h100, 1'b0, BR,   32'h40, 1'b1, 32'h80, 5'd0, 1'b0, 3'b111, 3'b000, 32'h0,  5'd0));
        s.push_back(mk(1'b0, 32'h40,  1'b0, NONE, 32'h0,  1'b0, 32'h0,  5'd0, 1'b0, 3'b111, 3'b110, 32'h80, 5'd0));
        s.push_back(mk(1'b0, 32'h100, 1'b0, NONE, 32'h0,  1'b0, 32'h0,  5'd0, 1'b0, 3'b111, 3'b000, 32'h0,  5'd1));
        s.push_back(mk(1'b0, 32'h40,  1'b1, NONE, 32'h0,  1'b0, 32'h0,  5'd0, 1'b0, 3'b111, 3'b010, 32'h80, 5'd1));
        s.push_back(mk(1'b0, 32'h100, 1'b0, NONE, 32'h0,  1'b0, 32'h0,  5'd0, 1'b0, 3'b111, 3'b000, 32'h0,  5'd1));
        s.push_back(mk(1'b0, 32'h40,  1'b0, NONE, 32'h0,  1'b0, 32'h0,  5'd0, 1'b0, 3'b111, 3'b010, 32'h80, 5'd1));
        s.push_back(mk(1'b0, 32'h100, 1'b0, NONE, 32'h0,  1'b0, 32'h0,  5'd0, 1'b0, 3'b111, 3'b000, 32'h0,  5'd2));
        for (int i = 0; i < s.size(); i++) begin
            drive_step(s[i]);
            #1;
            while (sb.size() > 0) begin
                e = sb.pop_front();
                obs = observe(e.dut);
                vectors++;
                if (obs !== e.val) begin
                    miscompares++;
                    $display("FAIL ghr_shift step %0d dut %0d: got taken=%b npc=%h ghr=%b, expected taken=%b npc=%h ghr=%b",
                             i, e.dut, obs[37], obs[36:5], obs[4:0], e.val[37], e.val[36:5], e.val[4:0]);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_repair();
        step_t s[$];
        exp_t e;
        logic [37:0] obs;
        s.push_back(mk(1'b1, 32'h100, 1'b0, NONE, 32'h0,   1'b0, 32'h0,   5'b00000, 1'b0, 3'b000, 3'b000, 32'h0,  5'd0));
        s.push_back(mk(1'b0, 32'h100, 1'b0, BR,   32'h40,  1'b1, 32'h80,  5'b00000, 1'b0, 3'b111, 3'b000, 32'h0,  5'd0));
        s.push_back(mk(1'b0, 32'h100, 1'b0, BR,   32'h40,  1'b1, 32'h80,  5'b00000, 1'b0, 3'b111, 3'b000, 32'h0,  5'd0));
        s.push_back(mk(1'b0, 32'h40,  1'b0, BR,   32'h200, 1'b1, 32'h400, 5'b00110, 1'b1, 3'b111, 3'b110, 32'h80, 5'd0));
        s.push_back(mk(1'b0, 32'h100, 1'b1, JMP,  32'h300, 1'b1, 32'h500, 5'b10101, 1'b1, 3'b111, 3'b000, 32'h0,  5'b01101));
        s.push_back(mk(1'b0, 32'h100, 1'b0, NONE, 32'h0,   1'b0, 32'h0,   5'b00000, 1'b0, 3'b111, 3'b000, 32'h0,  5'b10101));
        for (int i = 0; i < s.size(); i++) begin
            drive_step(s[i]);
            #1;
            while (sb.size() > 0) begin
                e = sb.pop_front();
                obs = observe(e.dut);
                vectors++;
                if (obs !== e.val) begin
                    miscompares++;
                    $display("FAIL repair step %0d dut %0d: got taken=%b npc=%h ghr=%b, expected taken=%b npc=%h ghr=%b",
                             i, e.dut, obs[37], obs[36:5], obs[4:0], e.val[37], e.val[36:5], e.val[4:0]);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_saturation();
        step_t s[$];
        exp_t e;
        logic [37:0] obs;
        s.push_back(mk(1'b1, 32'h100, 1'b0, NONE, 32'h0, 1'b0, 32'h0, 5'd0, 1'b0, 3'b000, 3'b000, 32'h0, 5'd0));
        for (int k = 0; k < 4; k++)
            s.push_back(mk(1'b0, 32'h100, 1'b0, BR, 32'h40, 1'b1, 32'h80, 5'd0, 1'b0, 3'b111, 3'b000, 32'h0, 5'd0));
        s.push_back(mk(1'b0, 32'h100, 1'b0, BR,   32'h40, 1'b0, 32'h80, 5'd0, 1'b0, 3'b111, 3'b000, 32'h0,  5'd0));
        s.push_back(mk(1'b0, 32'h40,  1'b1, NONE, 32'h0,  1'b0, 32'h0,  5'd0, 1'b0, 3'b111, 3'b110, 32'h80, 5'd0));
        s.push_back(mk(1'b0, 32'h100, 1'b0, BR,   32'h40, 1'b0, 32'h80, 5'd0, 1'b0, 3'b111, 3'b000, 32'h0,  5'd0));
        s.push_back(mk(1'b0, 32'h40,  1'b1, NONE, 32'h0,  1'b0, 32'h0,  5'd0, 1'b0, 3'b111, 3'b000, 32'h0,  5'd0));
        for (int k = 0; k < 3; k++)
            s.push_back(mk(1'b0, 32'h100, 1'b0, BR, 32'h40, 1'b0, 32'h80, 5'd0, 1'b0, 3'b111, 3'b000, 32'h0, 5'd0));
        s.push_back(mk(1'b0, 32'h100, 1'b0, BR,   32'h40, 1'b1, 32'h80, 5'd0, 1'b0, 3'b111, 3'b000, 32'h0,  5'd0));
        s.push_back(mk(1'b0, 32'h40,  1'b1, NONE, 32'h0,  1'b0, 32'h0,  5'd0, 1'b0, 3'b111, 3'b000, 32'h0,  5'd0));
        // Reset lands on a training cycle that also requests a repair.
        s.push_back(mk(1'b1, 32'h100, 1'b0, BR,   32'h40, 1'b1, 32'h80, 5'b11111, 1'b1, 3'b000, 3'b000, 32'h0, 5'd0));
        s.push_back(mk(1'b0, 32'h40,  1'b1, NONE, 32'h0,  1'b0, 32'h0,  5'd0, 1'b0, 3'b111, 3'b000, 32'h0,  5'd0));
        s.push_back(mk(1'b0, 32'h100, 1'b0, BR,   32'h40, 1'b1, 32'h80, 5'd0, 1'b0, 3'b111, 3'b000, 32'h0,  5'd0));
        s.push_back(mk(1'b0, 32'h40,  1'b1, NONE, 32'h0,  1'b0, 32'h0,  5'd0, 1'b0, 3'b111, 3'b110, 32'h80, 5'd0));
        for (int i = 0; i < s.size(); i++) begin
            drive_step(s[i]);
            #1;
            while (sb.size() > 0) begin
                e = sb.pop_front();
                obs = observe(e.dut);
                vectors++;
                if (obs !== e.val) begin
                    miscompares++;
                    $display("FAIL saturation step %0d dut %0d: got taken=%b npc=%h ghr=%b, expected taken=%b npc=%h ghr=%b",
                             i, e.dut, obs[37], obs[36:5], obs[4:0], e.val[37], e.val[36:5], e.val[4:0]);
                end
            end
            @(negedge clk);
        end
    endtask

    initial begin
        reset          = 1'b1;
        pred_pc        = 32'h0;
        stall          = 1'b0;
        upd_valid      = 1'b0;
        upd_pc         = 32'h0;
        upd_is_branch  = 1'b0;
        upd_is_jump    = 1'b0;
        upd_taken      = 1'b0;
        upd_target     = 32'h0;
        upd_ghr        = 5'd0;
        upd_mispredict = 1'b0;
        @(negedge clk);
        test_reset();
        test_bimodal();
        test_jump_alias();
        test_ghr_shift();
        test_repair();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Parametrised dynamic branch predictor for the 5-stage pipelined CPU. Sits beside the PC and instruction memory in IF: it looks up the current PC combinationally and supplies the next PC. It is trained from EX when a branch or jump resolves. It generalises the static predict-not-taken of the current pipeline into a selectable mode (static, bimodal, gshare). The block contains a tagged BTB, a PHT of 2-bit saturating counters and a speculative global history register with misprediction repair.

## Interface
Parameters:
- XLEN, 32, PC/target width.
- IDX_BITS, 5, index width; BTB and PHT each hold 2^IDX_BITS entries.
- GHR_BITS, 5, global history length; must satisfy 1 ≤ GHR_BITS ≤ IDX_BITS.
- MODE, 2, prediction mode: 0 = always not-taken, 1 = bimodal, 2 = gshare.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- pred_pc  in  XLEN  PC currently in IF.
- stall  in  1  IF stalled; freezes speculative GHR.
- pred_taken  out  1  predicted taken.
- pred_next_pc  out  XLEN  BTB target if pred_taken, else pred_pc+4.
- pred_ghr  out  GHR_BITS  GHR snapshot used for this lookup; carried down the pipeline.
- upd_valid  in  1  resolved control-flow instruction in EX this cycle.
- upd_pc  in  XLEN  PC of resolved instruction.
- upd_is_branch  in  1  conditional branch.
- upd_is_jump  in  1  JAL/JALR.
- upd_taken  in  1  actual outcome (1 for jumps).
- upd_target  in  XLEN  actual target.
- upd_ghr  in  GHR_BITS  pred_ghr captured when this instruction was fetched.
- upd_mispredict  in  1  pipeline is flushing due to this instruction.

## Operation
- **Index and tag:**
  - BTB index = pc[IDX_BITS+1:2].
  - Tag = pc[XLEN-1:IDX_BITS+2].
  - PHT index = BTB index in MODE 1; BTB index XOR zero-extended GHR in MODE 2.
- **Lookup:** hit = valid[idx] && tag match.
  - MODE 0: pred_taken = 0.
  - MODE 1/2: pred_taken = hit && (entry.is_jump || pht[pidx][1]).
- **PHT training:** on upd_valid && upd_is_branch, update the counter at the index computed from upd_pc and upd_ghr (never the live GHR).
  - Taken: increment, saturating at 3.
  - Not-taken: decrement, saturating at 0.
- **BTB allocation:** on upd_valid && upd_taken, write valid=1, tag, upd_target and is_jump=upd_is_jump.
  - A not-taken branch never allocates, but leaves an existing entry intact.
- **Speculative GHR (MODE 2 only; held at 0 otherwise):**
  - If !stall, and the lookup hits an entry with is_jump=0: GHR <= {GHR[GHR_BITS-2:0], pred_taken}.
- **Repair (priority over speculative shift):** when upd_valid && upd_mispredict:
  - Conditional branch: GHR <= {upd_ghr[GHR_BITS-2:0], upd_taken}.
  - Otherwise: GHR <= upd_ghr.
- **pred_ghr** equals the current GHR register value (pre-shift).

## Timing
- Lookup is purely combinational from pred_pc and state, in the same cycle; zero latency.
- Training and repair take effect at the next rising edge.
- A lookup in the same cycle as an update to the same entry returns the old contents.
- Reset (synchronous, any cycle, including mid-training):
  - All BTB valid bits = 0.
  - All PHT counters = 2'b01 (weakly not-taken).
  - GHR = 0.
  - In the cycle after reset: pred_taken=0, pred_next_pc=pred_pc+4, pred_ghr=0.
- Simultaneous speculative shift and repair: repair wins; the speculative shift is dropped.
- stall=1 with repair: repair still applies.
- Counter saturation: 3 + taken stays 3; 0 + not-taken stays 0.
- Aliasing: no disambiguation beyond the tag; PHT is untagged.

## Test plan
- Reset, then pred_pc=0x100 → pred_taken=0, pred_next_pc=0x104, pred_ghr=0.
- MODE 1: train branch at 0x40, taken to 0x80, twice → next lookup of 0x40 gives pred_taken=1, pred_next_pc=0x80. Train not-taken twice → pred_taken=0, BTB entry retained.
- JAL at 0x20 → 0x200 trained once → pred_taken=1 regardless of counter; a PC with the same index but different tag (0x20+4·2^IDX_BITS) → miss, next PC = PC+4.
- MODE 2: hit on a branch predicted taken with stall=0 → GHR shifts in 1. Same with stall=1 → GHR unchanged.
- Mispredict repair: upd_ghr=5'b00110, branch, upd_taken=1, in the same cycle as a speculative shift → GHR=5'b01101 next cycle.
- Counter saturation: 4 taken updates then 1 not-taken → counter=2, still predicts taken. Reset asserted mid-sequence → all state cleared as specified.
